regfile_wport_arbiter: RTL and testbench

- Owns the single write port (We/Wr/D) of the 32x32 register file.
- Shares the port between two sources: the in-order pipeline writeback (WB) and a long-latency unit (LU, mul/div/CP0) that uses a valid/ready handshake.
- Holds LU results in a small FIFO and keeps a per-register pending scoreboard, so decode can stall on RAW hazards against outstanding LU results.
- Sits between the WB stage / LU and the register file, and feeds the hazard inputs of the decode stage.

---
 rtl/regfile_wport_arbiter_pkg.sv | 19 +
 rtl/regfile_wfifo.sv | 52 +++++
 rtl/regfile_wport_arbiter.sv | 124 ++++++++++++
 tb/tb_regfile_wport_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wport_arbiter_pkg.sv
// regfile_wport_arbiter_pkg: shared widths and types for the register-file write-port arbiter.
// Rev 1.0
`default_nettype none

package regfile_wport_arbiter_pkg;

  localparam int unsigned RADDR_W  = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam logic [RADDR_W-1:0] R0 = 5'd0;

  typedef struct packed {
    logic [RADDR_W-1:0] wr;
    logic [DATA_W-1:0]  d;
  } wr_req_t;

endpackage

`default_nettype wire

// File: rtl/regfile_wfifo.sv
// regfile_wfifo: synchronous FIFO buffering long-latency results; full/empty from an extra pointer bit.
// Rev 1.0
`default_nettype none

module regfile_wfifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 37
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW:0]      wptr_q, wptr_d;
  logic [PW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    wptr_d  = wptr_q + (PW+1)'(push_i);
    rptr_d  = rptr_q + (PW+1)'(pop_i);
    empty_o = (wptr_q == rptr_q);
    full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    dout_o  = mem_q[rptr_q[PW-1:0]];
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: contents are only observable between push and pop.
  always_ff @(posedge Clk) begin
    if (push_i) begin
      mem_q[wptr_q[PW-1:0]] <= din_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter: shares the register-file write port between pipeline writeback and the
// long-latency unit, with a pending-register scoreboard and a WB starvation guard. Rev 1.0
`default_nettype none

module regfile_wport_arbiter
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               Clk,
  input  logic               Clrn,
  input  logic               wb_we,
  input  logic [RADDR_W-1:0] wb_wr,
  input  logic [DATA_W-1:0]  wb_d,
  output logic               wb_stall,
  input  logic               lu_valid,
  input  logic [RADDR_W-1:0] lu_wr,
  input  logic [DATA_W-1:0]  lu_d,
  output logic               lu_ready,
  input  logic               iss_valid,
  input  logic [RADDR_W-1:0] iss_wr,
  output logic               iss_block,
  input  logic [RADDR_W-1:0] chk_ra,
  input  logic [RADDR_W-1:0] chk_rb,
  output logic               hazard_a,
  output logic               hazard_b,
  output logic               We,
  output logic [RADDR_W-1:0] Wr,
  output logic [DATA_W-1:0]  D
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

  wr_req_t             head;
  wr_req_t             lu_req;
  logic                fifo_full, fifo_empty;
  logic                wb_grant, fifo_grant, push;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic                wb_stall_q, wb_stall_d;

  assign lu_req = '{wr: lu_wr, d: lu_d};

  regfile_wfifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(wr_req_t))
  ) u_wfifo (
    .Clk     (Clk),
    .Clrn    (Clrn),
    .push_i  (push),
    .pop_i   (fifo_grant),
    .din_i   (lu_req),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // WB has priority unless the guard has stalled it; the FIFO takes any idle port cycle.
  always_comb begin
    wb_grant   = wb_we && (wb_wr != R0) && !wb_stall_q;
    fifo_grant = !wb_grant && !fifo_empty;
    lu_ready   = !fifo_full || fifo_grant;
    push       = lu_valid && lu_ready && (lu_wr != R0);
    We         = wb_grant || fifo_grant;
    Wr         = R0;
    D          = '0;
    if (wb_grant) begin
      Wr = wb_wr;
      D  = wb_d;
    end else if (fifo_grant) begin
      Wr = head.wr;
      D  = head.d;
    end
  end

  // Clear before set so a same-cycle issue to the retiring register stays pending.
  always_comb begin
    pending_d = pending_q;
    if (fifo_grant) begin
      pending_d[head.wr] = 1'b0;
    end
    if (iss_valid && (iss_wr != R0)) begin
      pending_d[iss_wr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_comb begin
    starve_d   = '0;
    wb_stall_d = 1'b0;
    if (!fifo_empty && wb_grant) begin
      if (starve_q == CNT_LAST) begin
        wb_stall_d = 1'b1;
      end else begin
        starve_d = starve_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      pending_q  <= '0;
      starve_q   <= '0;
      wb_stall_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      starve_q   <= starve_d;
      wb_stall_q <= wb_stall_d;
    end
  end

  assign wb_stall  = wb_stall_q;
  assign iss_block = pending_q[iss_wr];
  assign hazard_a  = pending_q[chk_ra];
  assign hazard_b  = pending_q[chk_rb];

  a_no_issue_on_pending: assert property (@(posedge Clk) disable iff (!Clrn)
    !(iss_valid && iss_block));

endmodule

`default_nettype wire

// File: tb/tb_regfile_wport_arbiter.sv
// tb_regfile_wport_arbiter: randomized scoreboard bench for the register-file write-port arbiter.
// Rev 1.0
`default_nettype none

module tb_regfile_wport_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        Clk = 1'b0;
  logic        Clrn = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_wr = '0;
  logic [31:0] wb_d = '0;
  logic        lu_valid = 1'b0;
  logic [4:0]  lu_wr = '0;
  logic [31:0] lu_d = '0;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_wr = '0;
  logic [4:0]  chk_ra = '0;
  logic [4:0]  chk_rb = '0;
  logic        wb_stall, lu_ready, iss_block, hazard_a, hazard_b, We;
  logic [4:0]  Wr;
  logic [31:0] D;

  always #5 Clk = ~Clk;

  regfile_wport_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .Clk(Clk), .Clrn(Clrn),
    .wb_we(wb_we), .wb_wr(wb_wr), .wb_d(wb_d), .wb_stall(wb_stall),
    .lu_valid(lu_valid), .lu_wr(lu_wr), .lu_d(lu_d), .lu_ready(lu_ready),
    .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_block(iss_block),
    .chk_ra(chk_ra), .chk_rb(chk_rb), .hazard_a(hazard_a), .hazard_b(hazard_b),
    .We(We), .Wr(Wr), .D(D)
  );

  int tests = 0;
  int fails = 0;

  // Expected port writes, one entry per cycle in which the port should be written.
  logic [36:0] expq[$];

  // Reference model: buffered LU results, pending set, consecutive-loss run, stall flag.
  logic [36:0] mfifo[$];
  bit [31:0]   mpend;
  int          mrun;
  bit          mstall;
  bit          lu_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mfifo.delete();
    expq.delete();
    mpend  = '0;
    mrun   = 0;
    mstall = 1'b0;
    lu_acc = 1'b0;
  endtask

  task automatic cycle(input bit we, input logic [4:0] wr, input logic [31:0] d,
                       input bit lv, input logic [4:0] lwr, input logic [31:0] ld,
                       input bit iv, input logic [4:0] iwr,
                       input logic [4:0] ra, input logic [4:0] rb, input bit rst_mid);
    bit          wbg, fg, rdy, nonempty;
    logic [36:0] h;
    @(negedge Clk);
    Clrn      = 1'b1;
    wb_we     = we;  wb_wr  = wr;  wb_d = d;
    lu_valid  = lv;  lu_wr  = lwr; lu_d = ld;
    iss_valid = iv;  iss_wr = iwr;
    chk_ra    = ra;  chk_rb = rb;
    nonempty = (mfifo.size() != 0);
    wbg      = we && (wr != 5'd0) && !mstall;
    fg       = !wbg && nonempty;
    rdy      = (mfifo.size() < DEPTH) || fg;
    if (wbg) expq.push_back({wr, d});
    else if (fg) expq.push_back(mfifo[0]);
    #1;
    chk("lu_ready", 64'(lu_ready), 64'(rdy));
    chk("wb_stall", 64'(wb_stall), 64'(mstall));
    chk("iss_block", 64'(iss_block), 64'(mpend[iwr]));
    chk("hazard_a", 64'(hazard_a), 64'(mpend[ra]));
    chk("hazard_b", 64'(hazard_b), 64'(mpend[rb]));
    if (rst_mid) begin
      #2;
      Clrn = 1'b0;
      #1;
      chk("rst_lu_ready", 64'(lu_ready), 64'(1));
      chk("rst_we", 64'(We), 64'(0));
      chk("rst_hazards", 64'({hazard_a, hazard_b}), 64'(0));
      chk("rst_wb_stall", 64'(wb_stall), 64'(0));
      model_reset();
      return;
    end
    lu_acc = lv && rdy;
    if (fg) begin
      h = mfifo.pop_front();
      mpend[h[36:32]] = 1'b0;
    end
    if (lv && rdy && (lwr != 5'd0)) mfifo.push_back({lwr, ld});
    if (iv && (iwr != 5'd0)) mpend[iwr] = 1'b1;
    if (nonempty && wbg) mrun++;
    else mrun = 0;
    mstall = (mrun == LIMIT);
    if (mstall) mrun = 0;
  endtask

  task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, ra, rb, 1'b0);
  endtask

  // Monitor: every cycle compares the write port against the scoreboard.
  logic [36:0] mon_e;
  initial begin
    forever begin
      @(negedge Clk);
      #2;
      if (expq.size() != 0) begin
        mon_e = expq.pop_front();
        chk("port_write", 64'({We, Wr, D}), 64'({1'b1, mon_e}));
      end else begin
        chk("port_idle", 64'({We, Wr, D}), 64'(0));
      end
    end
  end

  initial begin
    bit          hwe, hlv, iv, s;
    logic [4:0]  hwr, hlwr, iwr;
    logic [31:0] hd, hld;
    int          r;
    model_reset();
    Clrn = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_lu_ready", 64'(lu_ready), 64'(1));
    chk("reset_port", 64'({We, Wr, D}), 64'(0));
    chk("reset_hazards", 64'({hazard_a, hazard_b, iss_block}), 64'(0));
    chk("reset_wb_stall", 64'(wb_stall), 64'(0));

    // Plain WB write.
    cycle(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd0, 1'b0);

    // Issue r5, observe hazard, then retire it through the LU path.
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd5, 5'd0, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h12, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0);
    idle(5'd5, 5'd0);
    idle(5'd5, 5'd0);

    // Starvation guard: LU r9 queued behind continuous WB to r1..r8.
    cycle(1'b1, 5'd1, 32'h101, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    r = 2;
    while (r <= 8) begin
      s = mstall;
      cycle(1'b1, 5'(r), 32'h100 + 32'(r), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0, 1'b0);
      if (!s) r++;
    end
    idle(5'd0, 5'd0);

    // Fill the FIFO under WB traffic, then release the port.
    cycle(1'b1, 5'd10, 32'h10A, 1'b1, 5'd10, 32'hA0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cycle(1'b1, 5'd11, 32'h10B, 1'b1, 5'd11, 32'hA1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cycle(1'b1, 5'd12, 32'h10C, 1'b1, 5'd12, 32'hA2, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hA2, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (3) idle(5'd0, 5'd0);

    // Writes to r0 from either source never reach the port.
    cycle(1'b1, 5'd0, 32'hBAD0, 1'b1, 5'd0, 32'hBAD1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    idle(5'd0, 5'd0);

    // Issue to r7 in the same cycle its stale LU result retires: pending must stay set.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0);
    idle(5'd7, 5'd0);

    // Asynchronous reset with buffered results and pending registers.
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 5'd0, 5'd0, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd21, 5'd0, 5'd0, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd22, 5'd0, 5'd0, 1'b0);
    cycle(1'b1, 5'd1, 32'h201, 1'b1, 5'd20, 32'hC20, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cycle(1'b1, 5'd2, 32'h202, 1'b1, 5'd21, 32'hC21, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cycle(1'b1, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd21, 5'd22, 1'b1);
    repeat (3) idle(5'd21, 5'd22);

    // Randomized traffic; stalled WB and back-pressured LU hold their values.
    hwe = 1'b0; hwr = '0; hd = '0; hlv = 1'b0; hlwr = '0; hld = '0;
    for (int n = 0; n < 600; n++) begin
      if (!mstall) begin
        hwe = ($urandom_range(0, 3) != 0);
        hwr = 5'($urandom_range(0, 31));
        hd  = $urandom;
      end
      if (!(hlv && !lu_acc)) begin
        hlv  = ($urandom_range(0, 2) == 0);
        hlwr = 5'($urandom_range(0, 31));
        for (int k = 0; k < 4 && !mpend[hlwr]; k++) hlwr = 5'($urandom_range(0, 31));
        hld  = $urandom;
      end
      iwr = 5'($urandom_range(0, 31));
      iv  = ($urandom_range(0, 3) == 0) && !mpend[iwr];
      cycle(hwe, hwr, hd, hlv, hlwr, hld, iv, iwr,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b0);
    end
    repeat (4) idle(5'd0, 5'd0);
    @(negedge Clk);
    #3;
    chk("scoreboard_drained", 64'(expq.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
